// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage: instruction fetch stage feeding decode.
// Owns the PC, fetches words over a req/ack handshake and holds the IF/ID
// register. Handles hazard stall, branch/jump redirect with flush, and
// variable-latency instruction memory.
// Optional macro IF_FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [5:0]  if_id_op,
    output logic [5:0]  if_id_funct,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic [31:0] if_id_pc4
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;   // target remembered while the killed fetch drains
    logic [31:0] skid;         // word accepted from memory while decode stalled
    logic [31:0] pc_plus4;
    logic [31:0] target;

    // Modulo-2^32 increment; 0xFFFF_FFFC wraps to 0 naturally.
    assign pc_plus4  = pc + 32'd4;
    assign target    = redirect_pc_i & ~32'h3;

    // A request stays up in KILL so the memory sees it completed, never retracted.
    assign imem_req    = (state == REQ) || (state == KILL);
    assign imem_addr   = pc;
    assign if_id_op    = if_id_instr[31:26];
    assign if_id_funct = if_id_instr[5:0];

    // Fetch FSM, PC and IF/ID register; redirect outranks ack, ack outranks stall.
    // NOTE: every register here uses <= so all next-state reads see the
    // pre-edge values, regardless of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pending_pc  <= 32'h0;
            skid        <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_i) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                    end
                end
                REQ: begin
                    if (redirect_i) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                        if (imem_ack) begin
                            pc <= target;
                        end else begin
                            pending_pc <= target;
                            state      <= KILL;
                        end
                    end else if (imem_ack) begin
                        if (!stall_i) begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pc_plus4;
                            pc          <= pc_plus4;
                        end else begin
                            skid  <= imem_rdata;
                            state <= HOLD;
                        end
                    end else if (!stall_i) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= 32'h0;
                        pc          <= target;
                        state       <= REQ;
                    end else if (!stall_i) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= skid;
                        if_id_pc4   <= pc_plus4;
                        pc          <= pc_plus4;
                        state       <= REQ;
                    end
                end
                KILL: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= 32'h0;
                    if (imem_ack) begin
                        pc    <= redirect_i ? target : pending_pc;
                        state <= REQ;
                    end else if (redirect_i) begin
                        pending_pc <= target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic load_valid;
    logic load_bubble;

    assign load_valid  = !redirect_i && !stall_i &&
                         (((state == REQ) && imem_ack) || (state == HOLD));
    assign load_bubble = redirect_i || ((state == REQ) && !imem_ack && !stall_i);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_bubbles <= 32'h0;
        end else begin
            if (load_valid)  perf_fetched <= perf_fetched + 32'd1;
            if (load_bubble) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage: directed vector table, hand-written corner sequences and
// a randomized run checked against a transaction-level fetch-order model.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_op;
    logic [5:0]  if_id_funct;
    logic [31:0] if_id_pc4;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_op     (if_id_op),
        .if_id_funct  (if_id_funct),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles),
`endif
        .if_id_pc4    (if_id_pc4)
    );

    // Instruction memory contents as a pure function of address (never zero).
    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return ((a * 32'h0019_660D) ^ 32'h3C6E_F35F) | 32'h1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present memory data for the current address, then advance one clock.
    task automatic tick();
        imem_rdata = mw(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] t);
        imem_ack      = a;
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = t;
    endtask

    // Reset, check reset values, release and step out of IDLE.
    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check({tag, "_rst_req"},   32'(imem_req),    32'h0);
        check({tag, "_rst_addr"},  imem_addr,        32'h0);
        check({tag, "_rst_valid"}, 32'(if_id_valid), 32'h0);
        check({tag, "_rst_instr"}, if_id_instr,      32'h0);
        check({tag, "_rst_pc4"},   if_id_pc4,        32'h0);
        check({tag, "_rst_opfn"},  {20'h0, if_id_op, if_id_funct}, 32'h0);
        rst = 1'b0;
        tick();
        check({tag, "_idle_req"},  32'(imem_req),    32'h1);
        check({tag, "_idle_addr"}, imem_addr,        32'h0);
    endtask

    typedef struct {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        ci;       // check instr even though valid=0 (plain bubble)
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a, input logic s, input logic r, input logic [31:0] t,
                       input logic eq, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep, input logic [31:0] ei, input logic ci);
        vec_t v;
        v.ack = a; v.stall = s; v.redir = r; v.tgt = t;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc4 = ep; v.e_instr = ei; v.ci = ci;
        vecs.push_back(v);
    endtask

    logic        p_req, p_ack, p_stall, p_redir;
    logic [31:0] p_addr, p_tgt, s_instr, s_pc4, exp_next;
    logic        s_valid;
    int          deliveries;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        imem_rdata = 32'h0;

        // ack, stall, redir, tgt | req, addr, valid, pc4, instr, ci
        add(1, 0, 0, 0,            1, 32'h04,  1, 32'h04,  mw(32'h00), 0);
        add(1, 0, 0, 0,            1, 32'h08,  1, 32'h08,  mw(32'h04), 0);
        add(1, 0, 0, 0,            1, 32'h0C,  1, 32'h0C,  mw(32'h08), 0);
        add(1, 0, 0, 0,            1, 32'h10,  1, 32'h10,  mw(32'h0C), 0);
        add(0, 0, 0, 0,            1, 32'h10,  0, 32'h0,   32'h0,      1);
        add(0, 0, 0, 0,            1, 32'h10,  0, 32'h0,   32'h0,      1);
        add(1, 0, 0, 0,            1, 32'h14,  1, 32'h14,  mw(32'h10), 0);
        add(1, 0, 0, 0,            1, 32'h18,  1, 32'h18,  mw(32'h14), 0);
        add(1, 0, 0, 0,            1, 32'h1C,  1, 32'h1C,  mw(32'h18), 0);
        add(1, 0, 0, 0,            1, 32'h20,  1, 32'h20,  mw(32'h1C), 0);
        add(1, 1, 0, 0,            0, 32'h20,  1, 32'h20,  mw(32'h1C), 0);
        add(1, 1, 0, 0,            0, 32'h20,  1, 32'h20,  mw(32'h1C), 0);
        add(1, 1, 0, 0,            0, 32'h20,  1, 32'h20,  mw(32'h1C), 0);
        add(1, 0, 0, 0,            1, 32'h24,  1, 32'h24,  mw(32'h20), 0);
        add(1, 0, 0, 0,            1, 32'h28,  1, 32'h28,  mw(32'h24), 0);
        add(1, 0, 0, 0,            1, 32'h2C,  1, 32'h2C,  mw(32'h28), 0);
        add(1, 0, 0, 0,            1, 32'h30,  1, 32'h30,  mw(32'h2C), 0);
        add(0, 0, 1, 32'h103,      1, 32'h30,  0, 32'h0,   32'h0,      0);
        add(0, 0, 0, 0,            1, 32'h30,  0, 32'h0,   32'h0,      0);
        add(1, 0, 0, 0,            1, 32'h100, 0, 32'h0,   32'h0,      0);
        add(1, 0, 0, 0,            1, 32'h104, 1, 32'h104, mw(32'h100), 0);
        add(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,  0);
        add(1, 0, 0, 0,            1, 32'h0,   1, 32'h0,   mw(32'hFFFF_FFFC), 0);
        add(1, 0, 0, 0,            1, 32'h4,   1, 32'h4,   mw(32'h0),  0);
        add(1, 1, 0, 0,            0, 32'h4,   1, 32'h4,   mw(32'h0),  0);
        add(0, 1, 1, 32'h200,      1, 32'h200, 0, 32'h0,   32'h0,      0);
        add(1, 0, 0, 0,            1, 32'h204, 1, 32'h204, mw(32'h200), 0);
        add(0, 1, 0, 0,            1, 32'h204, 1, 32'h204, mw(32'h200), 0);
        add(0, 0, 0, 0,            1, 32'h204, 0, 32'h0,   32'h0,      1);
        add(1, 0, 0, 0,            1, 32'h208, 1, 32'h208, mw(32'h204), 0);
        add(0, 0, 1, 32'h300,      1, 32'h208, 0, 32'h0,   32'h0,      0);
        add(0, 0, 1, 32'h402,      1, 32'h208, 0, 32'h0,   32'h0,      0);
        add(1, 0, 0, 0,            1, 32'h400, 0, 32'h0,   32'h0,      0);
        add(1, 0, 0, 0,            1, 32'h404, 1, 32'h404, mw(32'h400), 0);

        // ---------------- directed table ----------------
        do_reset("tbl");
        foreach (vecs[i]) begin
            drive(vecs[i].ack, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
            tick();
            check($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].e_req));
            check($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc4", i),   if_id_pc4,   vecs[i].e_pc4);
                check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
                check($sformatf("v%0d_op", i),    32'(if_id_op),    32'(vecs[i].e_instr[31:26]));
                check($sformatf("v%0d_funct", i), 32'(if_id_funct), 32'(vecs[i].e_instr[5:0]));
            end else if (vecs[i].ci) begin
                check($sformatf("v%0d_nop", i),   if_id_instr, 32'h0);
            end
            if (i == 0) begin
                check("first_op",    32'(if_id_op),    32'(6'b001000));
                check("first_funct", 32'(if_id_funct), 32'(6'b000101));
            end
        end

        // Reset in the middle of a killed fetch: asynchronous, clears everything.
        drive(1'b0, 1'b0, 1'b1, 32'h500);
        tick();
        check("kill_req", 32'(imem_req), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #2;
        check("async_rst_req",   32'(imem_req),    32'h0);
        check("async_rst_addr",  imem_addr,        32'h0);
        check("async_rst_valid", 32'(if_id_valid), 32'h0);

`ifdef IF_FETCH_PERF_CNT_EN
        // 5 fetches, 2 wait cycles, 1 redirect.
        do_reset("perf");
        for (int k = 0; k < 5; k++) begin drive(1, 0, 0, 0); tick(); end
        for (int k = 0; k < 2; k++) begin drive(0, 0, 0, 0); tick(); end
        drive(1, 0, 1, 32'h80);
        tick();
        drive(0, 0, 0, 0);
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_bubbles", perf_bubbles, 32'd3);
        rst = 1'b1;
        #2;
        check("perf_fetched_rst", perf_fetched, 32'd0);
        check("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif

        // ---------------- randomized run vs. fetch-order model ----------------
        // Model: delivered instructions form a sequential stream from RESET_PC,
        // restarting at each redirect target; stalls freeze IF/ID; a pending
        // request holds address until acked.
        do_reset("rnd");
        exp_next   = 32'h0;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 6, $urandom);
            p_req   = imem_req;   p_addr = imem_addr; p_ack = imem_ack;
            p_stall = stall_i;    p_redir = redirect_i; p_tgt = redirect_pc_i;
            s_valid = if_id_valid; s_instr = if_id_instr; s_pc4 = if_id_pc4;
            tick();
            if (p_req && !p_ack) begin
                check("rnd_req_hold",  32'(imem_req), 32'h1);
                check("rnd_addr_hold", imem_addr,     p_addr);
            end
            check("rnd_align", 32'(imem_addr[1:0]), 32'h0);
            check("rnd_opfn", {20'h0, if_id_op, if_id_funct},
                  {20'h0, if_id_instr[31:26], if_id_instr[5:0]});
            if (p_redir) begin
                check("rnd_flush", 32'(if_id_valid), 32'h0);
                exp_next = p_tgt & ~32'h3;
            end else if (p_stall) begin
                check("rnd_stall_valid", 32'(if_id_valid), 32'(s_valid));
                check("rnd_stall_instr", if_id_instr, s_instr);
                check("rnd_stall_pc4",   if_id_pc4,   s_pc4);
            end else if (if_id_valid) begin
                check("rnd_order", if_id_pc4 - 32'd4, exp_next);
                check("rnd_data",  if_id_instr, mw(exp_next));
                exp_next = exp_next + 32'd4;
                deliveries++;
            end else begin
                check("rnd_bubble", if_id_instr, 32'h0);
            end
        end
        check("rnd_progress", 32'(deliveries > 300), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
